// File: rtl/ddr3_rw_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rw_sched
// Brief    : Read/write BL8 command scheduler with contiguous burst framing,
//            read priority and a write-starvation bound. Optional bus
//            turnaround dead cycles: DDR3_SCHED_TURNAROUND_EN.
// Revision : 1.0
// ============================================================================
module ddr3_rw_sched #(
  parameter int ADDRS       = 32,
  parameter int REQID       = 4,
  parameter int STARVE      = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_store_i,
  output logic             wr_accept_o,
  input  logic             wr_wseq_i,
  input  logic [REQID-1:0] wr_wrid_i,
  input  logic [ADDRS-1:0] wr_addr_i,
  input  logic             rd_fetch_i,
  output logic             rd_accept_o,
  input  logic             rd_rseq_i,
  input  logic [REQID-1:0] rd_rdid_i,
  input  logic [ADDRS-1:0] rd_addr_i,
  output logic             ctl_req_o,
  input  logic             ctl_gnt_i,
  output logic             ctl_wren_o,
  output logic             ctl_seq_o,
  output logic [REQID-1:0] ctl_id_o,
  output logic [ADDRS-1:0] ctl_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
`ifdef DDR3_SCHED_TURNAROUND_EN
    , ST_TURN = 2'd3
`endif
  } state_t;

  localparam logic [3:0] c_STARVE = 4'(STARVE);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_first;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_in_wr;
  logic       w_in_rd;
  logic       w_head_vld;
  logic       w_end_burst;
  logic       w_xfer;
  logic       w_pick_wr;
  logic       w_any;

  assign w_in_wr   = (r_state == ST_WRITE);
  assign w_in_rd   = (r_state == ST_READ);
  assign w_any     = wr_store_i | rd_fetch_i;
  assign w_pick_wr = wr_store_i & (~rd_fetch_i | (r_starve_cnt == c_STARVE));

  // A seq=0 head after the first transfer belongs to the next burst.
  assign w_head_vld  = (w_in_wr & wr_store_i) | (w_in_rd & rd_fetch_i);
  assign w_end_burst = ~r_first & w_head_vld & ~ctl_seq_o;

  assign ctl_req_o   = w_head_vld & ~w_end_burst;
  assign w_xfer      = ctl_req_o & ctl_gnt_i;
  assign wr_accept_o = w_xfer & w_in_wr;
  assign rd_accept_o = w_xfer & w_in_rd;

  assign ctl_wren_o = w_in_wr;
  assign ctl_seq_o  = w_in_wr ? wr_wseq_i : rd_rseq_i;
  assign ctl_id_o   = w_in_wr ? wr_wrid_i : rd_rdid_i;
  assign ctl_addr_o = w_in_wr ? wr_addr_i : rd_addr_i;

`ifdef DDR3_SCHED_TURNAROUND_EN
  localparam int c_TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [c_TCW-1:0] c_TURN_LAST = c_TCW'(TURN_CYCLES - 1);

  logic             r_last_wr;
  logic             r_turn_wr;
  logic [c_TCW-1:0] r_turn_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_wr  <= 1'b0;
      r_turn_wr  <= 1'b0;
      r_turn_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_turn_cnt <= '0;
        r_turn_wr  <= w_pick_wr;
      end else if (r_state == ST_TURN) begin
        r_turn_cnt <= r_turn_cnt + c_TCW'(1);
      end
      if ((w_state_nxt == ST_WRITE) && (r_state != ST_WRITE)) begin
        r_last_wr <= 1'b1;
      end else if ((w_state_nxt == ST_READ) && (r_state != ST_READ)) begin
        r_last_wr <= 1'b0;
      end
    end
  end
`else
  // TURN_CYCLES only shapes the turnaround build.
  if (TURN_CYCLES < 0) begin : g_turn_unused
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          if (w_pick_wr) begin
            w_starve_nxt = '0;
          end else if (wr_store_i && (r_starve_cnt < c_STARVE)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
          end
          w_state_nxt = w_pick_wr ? ST_WRITE : ST_READ;
`ifdef DDR3_SCHED_TURNAROUND_EN
          if ((w_pick_wr != r_last_wr) && (TURN_CYCLES > 0)) begin
            w_state_nxt = ST_TURN;
          end
`endif
        end
      end
      ST_WRITE, ST_READ: begin
        if (w_end_burst) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef DDR3_SCHED_TURNAROUND_EN
      ST_TURN: begin
        if (r_turn_cnt == c_TURN_LAST) begin
          w_state_nxt = r_turn_wr ? ST_WRITE : ST_READ;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_first      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (!(w_in_wr || w_in_rd)) begin
        r_first <= 1'b1;
      end else if (w_xfer) begin
        r_first <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ddr3_rw_sched.md
# ddr3_rw_sched

Command scheduler between the AXI write path and the AXI read path of the DDR3 controller. It takes BL8 chunk commands from both paths' command FIFOs and presents one command at a time to the SDRAM command sequencer. Each multi-chunk burst stays contiguous, so a burst is never split by the other direction. Reads have priority, and a starvation limit bounds how long writes can be held off.

## Interface

Parameters:
- ADDRS, 32, command address width.
- REQID, 4, AXI transaction-ID width.
- STARVE, 4, maximum consecutive read bursts granted while a write is pending (1..15).
- TURN_CYCLES, 2, dead cycles inserted on a direction change (used only with the turnaround macro).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_store_i  in  1  write-command FIFO head valid
- wr_accept_o  out  1  pops the write-command FIFO head
- wr_wseq_i  in  1  head is a continuation chunk of the current burst
- wr_wrid_i  in  REQID  write ID
- wr_addr_i  in  ADDRS  write address
- rd_fetch_i  in  1  read-command FIFO head valid
- rd_accept_o  out  1  pops the read-command FIFO head
- rd_rseq_i  in  1  head is a continuation chunk
- rd_rdid_i  in  REQID  read ID
- rd_addr_i  in  ADDRS  read address
- ctl_req_o  out  1  command valid to the sequencer
- ctl_gnt_i  in  1  sequencer accepts the command
- ctl_wren_o  out  1  1 = write, 0 = read
- ctl_seq_o  out  1  continuation flag, passed through
- ctl_id_o  out  REQID  ID, passed through
- ctl_addr_o  out  ADDRS  address, passed through

## Operation

States:
- ST_IDLE: arbitration.
- ST_WRITE: write burst in progress.
- ST_READ: read burst in progress.
- ST_TURN: turnaround; exists only with the turnaround macro.

Arbitration, evaluated in ST_IDLE (registered; takes effect the next cycle):
- Only rd_fetch_i is high: go to ST_READ.
- Only wr_store_i is high: go to ST_WRITE.
- Both are high: go to ST_WRITE if starve_cnt == STARVE, otherwise ST_READ.

Datapath:
- ctl_req_o = (ST_WRITE & wr_store_i) | (ST_READ & rd_fetch_i) & !end_burst.
- The ctl_* fields are multiplexed combinationally from the selected source.
- A transfer occurs when ctl_req_o & ctl_gnt_i.
- wr_accept_o and rd_accept_o equal the transfer qualified by the state, so only the active source is popped.

Burst framing:
- A `first` flag is set on entry to ST_WRITE or ST_READ and cleared by the first transfer.
- end_burst = !first & head valid & head seq == 0.
- On end_burst the block returns to ST_IDLE without transferring; the next burst is re-arbitrated.
- An empty source mid-burst (valid low, `first` clear) holds the state. The burst is not abandoned, because upstream writes all chunks of a burst back-to-back.
- A head with seq == 1 while `first` is set (orphan chunk) is transferred normally.

Starvation counter (starve_cnt, 4 bits):
- Increments, saturating at STARVE, on each transition IDLE→READ taken while wr_store_i is high.
- Clears on IDLE→WRITE.

Sequencer handshake:
- The command must stay stable while ctl_req_o is high and ctl_gnt_i is low.
- The block never drops ctl_req_o before ctl_gnt_i, because the source FIFOs hold their heads.

## Timing

- Reset values: state ST_IDLE, starve_cnt 0, `first` 1, last_dir read, ctl_req_o 0, wr_accept_o 0, rd_accept_o 0.
- The ctl_* data outputs during reset are don't-care.
- Arbitration latency: a valid head in ST_IDLE gives ctl_req_o high on the following cycle.
- A burst of N chunks with ctl_gnt_i tied high issues in N consecutive cycles.
- The burst then ends with one cycle in which the next seq=0 head is seen (end_burst), and the block returns to ST_IDLE.
- Back-to-back bursts cost 2 cycles of bubble (end_burst cycle plus IDLE), or more when turnaround applies.
- Reset asserted mid-burst: all outputs are forced to their reset values immediately (asynchronous). Upstream FIFOs are reset on the same signal.
- Neither source valid in ST_IDLE: stay in ST_IDLE; starve_cnt is unchanged.

## Configuration

- DDR3_SCHED_TURNAROUND_EN defined:
  - When the arbitrated direction differs from last_dir, ST_IDLE goes to ST_TURN for exactly TURN_CYCLES cycles, with ctl_req_o = 0, then enters the chosen state.
  - last_dir updates on entry to ST_WRITE or ST_READ.
- DDR3_SCHED_TURNAROUND_EN undefined:
  - ST_TURN and last_dir are absent; a direction change costs no extra cycles.

## Test plan

- Read only: one 4-chunk read burst, ctl_gnt_i=1.
  - Required: ctl_req_o high 4 consecutive cycles, starting 1 cycle after rd_fetch_i, with ctl_wren_o=0 and ctl_seq_o sequence 0,1,1,1.
- Write only: one 2-chunk write burst.
  - Required: 2 transfers with ctl_wren_o=1; wr_accept_o pulses coincide with ctl_gnt_i.
- Contention: STARVE=4, both sources permanently loaded with 1-chunk bursts.
  - Required: grant pattern R,R,R,R,W repeating; starve_cnt is 0 after each W.
- Sequencer stall: ctl_gnt_i low for 5 cycles mid-burst.
  - Required: ctl_addr_o, ctl_id_o and ctl_seq_o stable for those 5 cycles; no accept pulses.
- Burst integrity: read burst of 4 in progress, write arrives after chunk 1.
  - Required: all 4 read chunks issue before the first write chunk.
  - Required with DDR3_SCHED_TURNAROUND_EN and TURN_CYCLES=2: exactly 2 idle ST_TURN cycles before the write.
- Async reset asserted mid-write-burst.
  - Required: ctl_req_o and wr_accept_o go to 0 in the same cycle; after release, state ST_IDLE and starve_cnt 0.
